clk_en_ctrl: RTL

//  Clock-enable and reset sequencer for the core clock domain, driven from the free-running clk.
//  - Holds core reset for a fixed post-reset window.
//  - Generates a divided single-cycle clk_en strobe for the pipeline.
//  - Supports debug halt/resume with a req/ack handshake and single-step while halted.
//  - Sits between the testbench/top clock source and the core's clock-enable and reset inputs.

---
 rtl/clk_pkg.sv | 26 ++
 rtl/mod_counter.sv | 33 +++
 rtl/clk_en_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_pkg
// Brief   : Shared types, default widths and helpers for the clock-enable
//           and reset sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package clk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } clk_ctrl_state_t;

    localparam int C_DIV_W    = 8;
    localparam int C_RST_HOLD = 16;
    localparam int C_TICK_W   = 32;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : clk_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : mod_counter
// Brief   : Up counter with synchronous clear, count enable and a
//           terminal-count flag (count >= terminal value).
// Revision: 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // ">=" so a terminal value that shrinks below the count fires at once.
    assign o_tc = (r_cnt >= i_term);

endmodule : mod_counter
`default_nettype wire

// File: rtl/clk_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_en_ctrl
// Brief   : Core reset hold, divided clk_en strobe and debug halt/step
//           sequencer for the core clock domain.
// Revision: 1.0 - initial release
// ============================================================================
module clk_en_ctrl
    import clk_pkg::*;
#(
    parameter int DIV_W    = C_DIV_W,
    parameter int RST_HOLD = C_RST_HOLD,
    parameter int TICK_W   = C_TICK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              halt_req,
    input  logic              step_req,
    output logic              core_rst,
    output logic              clk_en,
    output logic              halt_ack,
    output logic [TICK_W-1:0] tick_cnt
);

    localparam int                  c_hold_w    = cnt_w(RST_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_term = c_hold_w'(RST_HOLD - 1);

    clk_ctrl_state_t   r_state;
    clk_ctrl_state_t   w_state_nxt;
    logic              w_hold_tc;
    logic              w_div_tc;
    logic              w_div_clr;
    logic              w_clk_en_nxt;
    logic              w_tick_inc;
    logic              r_core_rst;
    logic              r_clk_en;
    logic              r_halt_ack;
    logic [TICK_W-1:0] r_tick_cnt;

    mod_counter #(
        .W (c_hold_w)
    ) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != HOLD),
        .i_en   (r_state == HOLD),
        .i_term (c_hold_term),
        .o_tc   (w_hold_tc)
    );

    // Divider restarts on every tick, on halt, and whenever not running.
    assign w_div_clr = (r_state != RUN) || halt_req || w_div_tc;

    mod_counter #(
        .W (DIV_W)
    ) u_div_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_div_clr),
        .i_en   (r_state == RUN),
        .i_term (div_val),
        .o_tc   (w_div_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD:    if (w_hold_tc) w_state_nxt = RUN;
            RUN:     if (halt_req)  w_state_nxt = HALTED;
            HALTED:  if (!halt_req) w_state_nxt = RUN;
            default: w_state_nxt = HOLD;
        endcase
    end

    // Halt beats a due tick; a step coinciding with resume is dropped.
    always_comb begin
        w_clk_en_nxt = 1'b0;
        w_tick_inc   = 1'b0;
        case (r_state)
            RUN: begin
                if (!halt_req && w_div_tc) begin
                    w_clk_en_nxt = 1'b1;
                    w_tick_inc   = 1'b1;
                end
            end
            HALTED: begin
                if (halt_req && step_req) begin
                    w_clk_en_nxt = 1'b1;
                    w_tick_inc   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst <= 1'b1;
            r_clk_en   <= 1'b0;
            r_halt_ack <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_core_rst <= (w_state_nxt == HOLD);
            r_clk_en   <= w_clk_en_nxt;
            r_halt_ack <= (w_state_nxt == HALTED);
            if (w_tick_inc) begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
        end
    end

    assign core_rst = r_core_rst;
    assign clk_en   = r_clk_en;
    assign halt_ack = r_halt_ack;
    assign tick_cnt = r_tick_cnt;

endmodule : clk_en_ctrl
`default_nettype wire
